// File: rtl/accel_muldiv.sv
// ============================================================================
// Module   : accel_muldiv
// Brief    : Iterative unsigned multiply/divide accelerator on the CPU
//            accelerator port. Define ACCEL_MULDIV_DIV_EN to build the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module accel_muldiv #(
    parameter int unsigned ACCEL_ID = 1,
    parameter int unsigned WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       accel_id,
    output logic             can_write,
    output logic             can_read,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [3:0]  ID_C  = 4'(ACCEL_ID);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_LOAD_A   = 3'd0,
        S_LOAD_B   = 3'd1,
        S_LOAD_CMD = 3'd2,
        S_BUSY     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [1:0]             cmd_q, cmd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;

    logic                   w_id_hit;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_prod_nxt;
    logic [WIDTH-1:0]       w_res;

    assign w_id_hit = (accel_id == ID_C);

    // Shift-add step: conditionally add A into the upper half, then shift right with carry.
    assign w_mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign w_prod_nxt = {w_mul_sum, prod_q[WIDTH-1:1]};

`ifdef ACCEL_MULDIV_DIV_EN
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH:0]         w_div_shift;
    logic                   w_div_ge;
    logic [WIDTH-1:0]       w_div_diff;
    logic [WIDTH-1:0]       w_rem_nxt;
    logic [WIDTH-1:0]       w_quo_nxt;

    // Restoring step: with B=0 every subtract succeeds, giving all-ones quotient and remainder A.
    assign w_div_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, b_q});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - b_q;
    assign w_rem_nxt   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_quo_nxt   = {quo_q[WIDTH-2:0], w_div_ge};
`endif

    always_comb begin
        w_res = '0;
        case (cmd_q)
            2'd0: w_res = w_prod_nxt[WIDTH-1:0];
            2'd1: w_res = w_prod_nxt[2*WIDTH-1:WIDTH];
`ifdef ACCEL_MULDIV_DIV_EN
            2'd2: w_res = w_quo_nxt;
            2'd3: w_res = w_rem_nxt;
`endif
            default: w_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rdata_d   = rdata_q;
`ifdef ACCEL_MULDIV_DIV_EN
        rem_d     = rem_q;
        quo_d     = quo_q;
`endif
        can_write = 1'b0;
        can_read  = 1'b0;

        case (state_q)
            S_LOAD_A: begin
                can_write = 1'b1;
                if (write_enable && w_id_hit) begin
                    a_d     = write_data;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                can_write = 1'b1;
                if (write_enable && w_id_hit) begin
                    b_d     = write_data;
                    state_d = S_LOAD_CMD;
                end
            end
            S_LOAD_CMD: begin
                can_write = 1'b1;
                if (write_enable && w_id_hit) begin
                    cmd_d   = write_data[1:0];
                    cnt_d   = '0;
                    prod_d  = {{WIDTH{1'b0}}, b_q};
`ifdef ACCEL_MULDIV_DIV_EN
                    rem_d   = '0;
                    quo_d   = a_q;
`endif
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                prod_d = w_prod_nxt;
`ifdef ACCEL_MULDIV_DIV_EN
                rem_d  = w_rem_nxt;
                quo_d  = w_quo_nxt;
`endif
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_C) begin
                    rdata_d = w_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                can_read = 1'b1;
                if (read_enable && w_id_hit) begin
                    state_d = S_LOAD_A;
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            rdata_q <= '0;
`ifdef ACCEL_MULDIV_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rdata_q <= rdata_d;
`ifdef ACCEL_MULDIV_DIV_EN
            rem_q   <= rem_d;
            quo_q   <= quo_d;
`endif
        end
    end

    assign read_data = rdata_q;

endmodule

`default_nettype wire
